// File: rtl/div_pkg.sv
// Shared types and constants for the divider round-trip (reconstruction) block.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DIV_WIDTH = 16;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_reconstruct_dp.sv
// Shift-add datapath: rebuilds quotient*divisor + remainder one multiplier bit per step,
// and registers the remainder-legality flag at load time.
module div_reconstruct_dp
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   quotient,
    input  logic [WIDTH-1:0]   divisor,
    input  logic [WIDTH-1:0]   remainder,
    output logic               last,
    output logic [2*WIDTH-1:0] dividend,
    output logic               rem_ok
);

    localparam int unsigned CW = cnt_width(WIDTH);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mult_q, mult_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] dividend_q, dividend_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               rem_ok_q, rem_ok_d;
    logic [2*WIDTH-1:0] sum;

    assign last     = (cnt_q == CW'(WIDTH - 1));
    assign dividend = dividend_q;
    assign rem_ok   = rem_ok_q;

    always_comb begin
        mcand_d    = mcand_q;
        mult_d     = mult_q;
        acc_d      = acc_q;
        dividend_d = dividend_q;
        cnt_d      = cnt_q;
        rem_ok_d   = rem_ok_q;
        sum        = acc_q + (mult_q[0] ? mcand_q : '0);

        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, divisor};
            mult_d   = quotient;
            acc_d    = {{WIDTH{1'b0}}, remainder};
            cnt_d    = '0;
            rem_ok_d = (divisor != '0) && (remainder < divisor);
        end else if (step) begin
            acc_d   = sum;
            mcand_d = mcand_q << 1;
            mult_d  = mult_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            // Result register only moves on the final step so it holds outside DONE.
            if (last) begin
                dividend_d = sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q    <= '0;
            mult_q     <= '0;
            acc_q      <= '0;
            dividend_q <= '0;
            cnt_q      <= '0;
            rem_ok_q   <= 1'b0;
        end else begin
            mcand_q    <= mcand_d;
            mult_q     <= mult_d;
            acc_q      <= acc_d;
            dividend_q <= dividend_d;
            cnt_q      <= cnt_d;
            rem_ok_q   <= rem_ok_d;
        end
    end

endmodule

// File: rtl/div_reconstruct.sv
// Rebuilds dividend = quotient*divisor + remainder with a fixed WIDTH-cycle latency,
// behind valid/ready handshakes on both sides.
module div_reconstruct
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   quotient,
    input  logic [WIDTH-1:0]   divisor,
    input  logic [WIDTH-1:0]   remainder,
    input  logic               src_valid,
    output logic               src_ready,
    output logic               dest_valid,
    input  logic               dest_ready,
    output logic [2*WIDTH-1:0] dividend,
    output logic               rem_ok
);

    state_e state_q, state_d;
    logic   load;
    logic   step;
    logic   last;

    div_reconstruct_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .quotient  (quotient),
        .divisor   (divisor),
        .remainder (remainder),
        .last      (last),
        .dividend  (dividend),
        .rem_ok    (rem_ok)
    );

    assign src_ready  = (state_q == IDLE);
    assign dest_valid = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (src_valid) begin
                    load    = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (dest_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_div_reconstruct.sv
// Scoreboard bench for div_reconstruct: expected results queued at acceptance, checked at output.
module tb_div_reconstruct;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic [2*W-1:0] dvd;
        logic           ok;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   quotient = '0;
    logic [W-1:0]   divisor = '0;
    logic [W-1:0]   remainder = '0;
    logic           src_valid = 1'b0;
    logic           src_ready;
    logic           dest_valid;
    logic           dest_ready = 1'b0;
    logic [2*W-1:0] dividend;
    logic           rem_ok;

    int unsigned total = 0;
    int unsigned bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    div_reconstruct #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .quotient   (quotient),
        .divisor    (divisor),
        .remainder  (remainder),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .dest_valid (dest_valid),
        .dest_ready (dest_ready),
        .dividend   (dividend),
        .rem_ok     (rem_ok)
    );

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_op(input logic [W-1:0] q, input logic [W-1:0] d,
                           input logic [W-1:0] r, output bit ok);
        exp_t e;
        int unsigned n = 0;
        while (src_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (src_ready === 1'b1);
        if (!ok) return;
        quotient  = q;
        divisor   = d;
        remainder = r;
        src_valid = 1'b1;
        @(posedge clk);
        e.dvd = (2*W)'(q) * (2*W)'(d) + (2*W)'(r);
        e.ok  = (d != 0) && (r < d);
        sb.push_back(e);
        @(negedge clk);
        src_valid = 1'b0;
        quotient  = $urandom;
        divisor   = $urandom;
        remainder = $urandom;
    endtask

    task automatic wait_valid(output int unsigned cycles, output bit ok);
        cycles = 0;
        while (dest_valid !== 1'b1 && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        ok = (dest_valid === 1'b1);
    endtask

    task automatic consume();
        dest_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dest_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({src_ready, dest_valid, rem_ok} !== 3'b100 || dividend !== '0) begin
            bad++;
            $display("FAIL reset: rdy/vld/ok=%b dvd=%0d want 100 0",
                     {src_ready, dest_valid, rem_ok}, dividend);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (src_ready !== 1'b1 || dest_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: rdy=%b vld=%b want 1 0", src_ready, dest_valid);
        end
    endtask

    // One plain operation: latency, value, flag and handshake return are all checked.
    task automatic test_single(input string name, input logic [W-1:0] q,
                               input logic [W-1:0] d, input logic [W-1:0] r);
        bit ok;
        int unsigned cyc;
        exp_t e;
        send_op(q, d, r, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_accept: src_ready never 1", name);
            return;
        end
        wait_valid(cyc, ok);
        total++;
        if (!ok || cyc != W) begin
            bad++;
            $display("FAIL %s_latency: got %0d want %0d", name, cyc, W);
        end
        e = sb.pop_front();
        total++;
        if (dividend !== e.dvd) begin
            bad++;
            $display("FAIL %s_dividend: got %0d want %0d", name, dividend, e.dvd);
        end
        total++;
        if (rem_ok !== e.ok) begin
            bad++;
            $display("FAIL %s_rem_ok: got %b want %b", name, rem_ok, e.ok);
        end
        consume();
        total++;
        if (src_ready !== 1'b1 || dest_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_release: rdy=%b vld=%b want 1 0", name, src_ready, dest_valid);
        end
    endtask

    task automatic test_fixed_values();
        exp_t chk[$];
        test_single("max_quot", 16'd65535, 16'd1, 16'd0);
        test_single("max_all", 16'd65535, 16'd65535, 16'd65534);
        test_single("div_zero", 16'd5, 16'd0, 16'd3);
        test_single("rem_big", 16'd10, 16'd3, 16'd5);
        // Independent spot-check of the model against hand-computed constants.
        chk.push_back('{dvd: 32'hFFFEFFFF, ok: 1'b1});
        total++;
        if ((32'(16'hFFFF) * 32'(16'hFFFF) + 32'(16'hFFFE)) !== chk[0].dvd) begin
            bad++;
            $display("FAIL model_max: got %h want %h",
                     32'(16'hFFFF) * 32'(16'hFFFF) + 32'(16'hFFFE), chk[0].dvd);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int unsigned cyc;
        int unsigned errs = 0;
        exp_t e;
        send_op(16'd0, 16'd7, 16'd6, ok);
        wait_valid(cyc, ok);
        total++;
        if (!ok || cyc != W) begin
            bad++;
            $display("FAIL bp_latency: got %0d want %0d", cyc, W);
        end
        e = sb.pop_front();
        for (int i = 0; i < 20; i++) begin
            quotient  = 16'd9;
            divisor   = 16'd2;
            remainder = 16'd1;
            src_valid = (i % 4 == 1);
            @(negedge clk);
            total++;
            if (dividend !== e.dvd || rem_ok !== e.ok || dest_valid !== 1'b1
                || src_ready !== 1'b0) begin
                bad++;
                errs++;
                if (errs < 4)
                    $display("FAIL bp_hold[%0d]: dvd=%0d ok=%b vld=%b rdy=%b want %0d %b 1 0",
                             i, dividend, rem_ok, dest_valid, src_ready, e.dvd, e.ok);
            end
        end
        src_valid = 1'b0;
        consume();
        total++;
        if (src_ready !== 1'b1 || dest_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: rdy=%b vld=%b want 1 0", src_ready, dest_valid);
        end
        repeat (W + 4) @(negedge clk);
        total++;
        if (dest_valid !== 1'b0 || src_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_no_take: vld=%b rdy=%b want 0 1", dest_valid, src_ready);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        send_op(16'd1000, 16'd3, 16'd1, ok);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        total++;
        if (dest_valid !== 1'b0 || src_ready !== 1'b1 || dividend !== '0) begin
            bad++;
            $display("FAIL mid_reset: vld=%b rdy=%b dvd=%0d want 0 1 0",
                     dest_valid, src_ready, dividend);
        end
        repeat (W + 2) @(negedge clk);
        total++;
        if (dest_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_abandon: vld=%b want 0", dest_valid);
        end
        test_single("after_reset", 16'd123, 16'd45, 16'd44);
    endtask

    // Round trip: divide a random dividend in the bench, rebuild it in the DUT.
    task automatic test_round_trip();
        bit ok;
        int unsigned cyc;
        int unsigned errs = 0;
        exp_t e;
        logic [W-1:0]   dvs;
        logic [63:0]    lim, raw, dvd;
        for (int i = 0; i < 400; i++) begin
            dvs = (i % 8 == 0) ? W'($urandom_range(1, 15)) : W'($urandom_range(1, 65535));
            lim = 64'(dvs) << W;
            raw = {$urandom, $urandom};
            dvd = raw % lim;
            send_op(W'(dvd / 64'(dvs)), W'(dvd % 64'(dvs)) == W'(dvd % 64'(dvs)) ? dvs : dvs,
                    W'(dvd % 64'(dvs)), ok);
            wait_valid(cyc, ok);
            if (sb.size() != 0) e = sb.pop_front();
            total++;
            if (!ok || dividend !== dvd[2*W-1:0] || rem_ok !== 1'b1 || cyc != W) begin
                bad++;
                errs++;
                if (errs < 6)
                    $display("FAIL round_trip[%0d]: dvd=%0d ok=%b lat=%0d want %0d 1 %0d",
                             i, dividend, rem_ok, cyc, dvd[2*W-1:0], W);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            consume();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_fixed_values();
        test_backpressure();
        test_reset_mid();
        test_round_trip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
